// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: load encodings, default source lanes, size helpers.
package wb_pkg;

    localparam int unsigned FUNCT3_W = 3;

    // Load size/sign encodings carried on ld_funct3
    typedef enum logic [FUNCT3_W-1:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_RAW = 3'b111
    } ld_funct3_e;

    // Default result-source lane assignment
    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MEM = 1;
    localparam int unsigned SRC_PC4 = 2;
    localparam int unsigned SRC_IMM = 3;

    // Access size in bytes; the unshifted raw view never misaligns, so it reports 1
    function automatic logic [3:0] size_of(input logic [FUNCT3_W-1:0] funct3);
        logic [3:0] size;
        case (ld_funct3_e'(funct3))
            F3_LB, F3_LBU: size = 4'd1;
            F3_LH, F3_LHU: size = 4'd2;
            F3_LW, F3_LWU: size = 4'd4;
            F3_LD:         size = 4'd8;
            default:       size = 4'd1;
        endcase
        return size;
    endfunction

    // On a 32-bit datapath the doubleword, unsigned-word and raw encodings collapse to LW
    function automatic logic [FUNCT3_W-1:0] narrow_funct3(input logic [FUNCT3_W-1:0] funct3,
                                                          input int unsigned xlen);
        logic [FUNCT3_W-1:0] f3;
        f3 = funct3;
        if (xlen == 32) begin
            if (funct3 == F3_LD || funct3 == F3_LWU || funct3 == F3_RAW) begin
                f3 = F3_LW;
            end
        end
        return f3;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: shift by byte offset, extend by access size, flag misalignment.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]     raw,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [OFF_W-1:0]    off,
    output logic [XLEN-1:0]     data_c,
    output logic                misalign_c
);

    logic [FUNCT3_W-1:0] f3_eff;
    logic [XLEN-1:0]     shifted;
    logic [3:0]          size;
    logic [OFF_W-1:0]    size_mask;

    // Shift, select and extend; misaligned accesses still deliver truncated shifted data
    always_comb begin
        f3_eff     = narrow_funct3(funct3, XLEN);
        shifted    = raw >> {off, 3'b000};
        size       = size_of(f3_eff);
        size_mask  = OFF_W'(size - 4'd1);
        misalign_c = |(off & size_mask);
        data_c     = shifted;
        case (ld_funct3_e'(f3_eff))
            F3_LB:   data_c = XLEN'($signed(shifted[7:0]));
            F3_LBU:  data_c = XLEN'(shifted[7:0]);
            F3_LH:   data_c = XLEN'($signed(shifted[15:0]));
            F3_LHU:  data_c = XLEN'(shifted[15:0]);
            F3_LW:   data_c = XLEN'($signed(shifted[31:0]));
            F3_LWU:  data_c = XLEN'(shifted[31:0]);
            F3_LD:   data_c = shifted;
            F3_RAW:  data_c = raw;
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: source select, load alignment, one-cycle output register, retire counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NSRC    = 4,
    parameter int unsigned MEM_SRC = SRC_MEM,
    parameter int unsigned RADDR_W = 5,
    localparam int unsigned SEL_W  = $clog2(NSRC),
    localparam int unsigned OFF_W  = $clog2(XLEN / 8)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [SEL_W-1:0]     wb_sel,
    input  logic                 reg_write,
    input  logic [RADDR_W-1:0]   rd,
    input  logic [FUNCT3_W-1:0]  ld_funct3,
    input  logic [OFF_W-1:0]     ld_off,
    output logic                 rf_we,
    output logic [RADDR_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 out_valid,
    output logic                 misalign,
    output logic [63:0]          instret
);

    logic [XLEN-1:0]    mem_aligned;
    logic               mem_misalign;
    logic               sel_is_mem;
    logic [XLEN-1:0]    wdata_d;
    logic               misalign_d;

    logic               valid_q;
    logic               rf_we_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    wdata_q;
    logic               misalign_q;
    logic [63:0]        instret_q;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .raw        (src_data[MEM_SRC*XLEN +: XLEN]),
        .funct3     (ld_funct3),
        .off        (ld_off),
        .data_c     (mem_aligned),
        .misalign_c (mem_misalign)
    );

    // Hazard unit hold is the only backpressure
    assign in_ready = ~stall;

    // Result-source mux; out-of-range selects yield zero, the memory lane takes aligned data
    always_comb begin
        wdata_d    = '0;
        sel_is_mem = (wb_sel == SEL_W'(MEM_SRC));
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (wb_sel == SEL_W'(i)) begin
                wdata_d = src_data[i*XLEN +: XLEN];
            end
        end
        if (sel_is_mem) begin
            wdata_d = mem_aligned;
        end
        misalign_d = sel_is_mem & mem_misalign;
    end

    // Output register: reset > flush/stall > capture > bubble; payload held when not capturing
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
        end else if (flush || stall) begin
            valid_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (in_valid) begin
            valid_q    <= 1'b1;
            rf_we_q    <= reg_write & (rd != '0);
            rd_q       <= rd;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
        end else begin
            valid_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            misalign_q <= 1'b0;
        end
    end

    // Retired-instruction counter, bumps on the edge after each committed instruction
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else if (valid_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign out_valid = valid_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = wdata_q;
    assign misalign  = misalign_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expected values.
module tb_wb_stage;
    import wb_pkg::*;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned NSRC    = 4;
    localparam int unsigned RADDR_W = 5;

    logic                 clk;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 stall;
    logic                 flush;
    logic [NSRC*XLEN-1:0] src_data;
    logic [1:0]           wb_sel;
    logic                 reg_write;
    logic [RADDR_W-1:0]   rd;
    logic [2:0]           ld_funct3;
    logic [2:0]           ld_off;
    logic                 rf_we;
    logic [RADDR_W-1:0]   rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 out_valid;
    logic                 misalign;
    logic [63:0]          instret;

    int          compared   = 0;
    int          mismatched = 0;
    logic        exp_ov     = 1'b0;
    logic [63:0] exp_ret    = '0;

    localparam logic [63:0] RAW_A = 64'h0000_0000_8000_FF80;
    localparam logic [63:0] RAW_B = 64'h1122_3344_5566_7788;

    wb_stage #(
        .XLEN    (XLEN),
        .NSRC    (NSRC),
        .MEM_SRC (SRC_MEM),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .src_data  (src_data),
        .wb_sel    (wb_sel),
        .reg_write (reg_write),
        .rd        (rd),
        .ld_funct3 (ld_funct3),
        .ld_off    (ld_off),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .out_valid (out_valid),
        .misalign  (misalign),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [2:0] off, input logic rw, input logic [4:0] r);
        in_valid  = v;
        wb_sel    = sel;
        ld_funct3 = f3;
        ld_off    = off;
        reg_write = rw;
        rd        = r;
    endtask

    // One clock: expected out_valid/instret follow from what was driven before the edge
    task automatic tick();
        logic cap;
        cap = reset_n && in_valid && !stall && !flush;
        @(posedge clk);
        if (!reset_n) exp_ret = '0;
        else if (exp_ov) exp_ret = exp_ret + 64'd1;
        exp_ov = cap;
        #1;
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("instret", instret, exp_ret);
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr,
                          input logic [63:0] data, input logic mis);
        chk({tag, ".rf_we"},    64'(rf_we),    64'(we));
        chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(addr));
        chk({tag, ".rf_wdata"}, rf_wdata,      data);
        chk({tag, ".misalign"}, 64'(misalign), 64'(mis));
    endtask

    initial begin
        reset_n  = 1'b0;
        stall    = 1'b1;
        flush    = 1'b0;
        src_data = '0;
        src_data[0*64 +: 64] = 64'h1234;
        src_data[1*64 +: 64] = RAW_A;
        src_data[2*64 +: 64] = 64'hAAAA_0000_0000_0004;
        src_data[3*64 +: 64] = 64'h0000_0000_0000_0FFF;
        issue(1'b1, 2'd0, F3_LB, 3'd0, 1'b1, 5'd5);

        // Reset held two cycles with valid input present
        #1;
        chk("reset.in_ready_stalled", 64'(in_ready), 64'd0);
        stall = 1'b0;
        #1;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        chk_wr("reset", 1'b0, 5'd0, 64'd0, 1'b0);

        // ALU path, first capture after release
        reset_n = 1'b1;
        tick();
        chk_wr("alu", 1'b1, 5'd5, 64'h1234, 1'b0);

        // Load extension, back to back from the memory lane
        issue(1'b1, 2'd1, F3_LB, 3'd0, 1'b1, 5'd7);
        tick();
        chk_wr("lb", 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        issue(1'b1, 2'd1, F3_LBU, 3'd0, 1'b1, 5'd7);
        tick();
        chk_wr("lbu", 1'b1, 5'd7, 64'h80, 1'b0);
        issue(1'b1, 2'd1, F3_LH, 3'd2, 1'b1, 5'd7);
        tick();
        chk_wr("lh_off2", 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
        issue(1'b1, 2'd1, F3_LWU, 3'd4, 1'b1, 5'd7);
        tick();
        chk_wr("lwu_off4", 1'b1, 5'd7, 64'h0, 1'b0);
        issue(1'b1, 2'd1, F3_LW, 3'd2, 1'b1, 5'd7);
        tick();
        chk_wr("lw_off2_mis", 1'b1, 5'd7, 64'h8000, 1'b1);

        src_data[1*64 +: 64] = RAW_B;
        issue(1'b1, 2'd1, F3_LW, 3'd2, 1'b1, 5'd8);
        tick();
        chk_wr("lw_b_off2_mis", 1'b1, 5'd8, 64'h3344_5566, 1'b1);
        issue(1'b1, 2'd1, F3_LH, 3'd1, 1'b1, 5'd8);
        tick();
        chk_wr("lh_b_off1_mis", 1'b1, 5'd8, 64'h6677, 1'b1);
        issue(1'b1, 2'd1, F3_LD, 3'd0, 1'b1, 5'd8);
        tick();
        chk_wr("ld_b", 1'b1, 5'd8, RAW_B, 1'b0);
        issue(1'b1, 2'd1, F3_LD, 3'd4, 1'b1, 5'd8);
        tick();
        chk_wr("ld_b_off4_mis", 1'b1, 5'd8, 64'h1122_3344, 1'b1);
        issue(1'b1, 2'd1, F3_RAW, 3'd3, 1'b1, 5'd8);
        tick();
        chk_wr("raw_b_off3", 1'b1, 5'd8, RAW_B, 1'b0);
        issue(1'b1, 2'd1, F3_LBU, 3'd7, 1'b1, 5'd8);
        tick();
        chk_wr("lbu_b_off7", 1'b1, 5'd8, 64'h11, 1'b0);

        // Non-memory source ignores load controls
        issue(1'b1, 2'd2, F3_LW, 3'd2, 1'b1, 5'd9);
        tick();
        chk_wr("pc4_lane", 1'b1, 5'd9, 64'hAAAA_0000_0000_0004, 1'b0);

        // x0 destination and non-writing instruction still retire
        issue(1'b1, 2'd3, F3_LB, 3'd0, 1'b1, 5'd0);
        tick();
        chk_wr("x0", 1'b0, 5'd0, 64'h0FFF, 1'b0);
        issue(1'b1, 2'd0, F3_LB, 3'd0, 1'b0, 5'd3);
        tick();
        chk_wr("no_regwrite", 1'b0, 5'd3, 64'h1234, 1'b0);

        // Stall: no capture, payload held
        issue(1'b1, 2'd2, F3_LB, 3'd0, 1'b1, 5'd12);
        stall = 1'b1;
        #1;
        chk("stall.in_ready", 64'(in_ready), 64'd0);
        tick();
        chk_wr("stall", 1'b0, 5'd3, 64'h1234, 1'b0);
        stall = 1'b0;

        // Flush with valid input
        flush = 1'b1;
        tick();
        chk_wr("flush", 1'b0, 5'd3, 64'h1234, 1'b0);

        // Flush and stall together
        stall = 1'b1;
        tick();
        chk_wr("flush_stall", 1'b0, 5'd3, 64'h1234, 1'b0);
        stall = 1'b0;
        flush = 1'b0;

        // Back-to-back writes to the same register
        src_data[0*64 +: 64] = 64'hA;
        issue(1'b1, 2'd0, F3_LB, 3'd0, 1'b1, 5'd9);
        tick();
        chk_wr("b2b_first", 1'b1, 5'd9, 64'hA, 1'b0);
        src_data[0*64 +: 64] = 64'hB;
        tick();
        chk_wr("b2b_second", 1'b1, 5'd9, 64'hB, 1'b0);
        issue(1'b0, 2'd0, F3_LB, 3'd0, 1'b1, 5'd9);
        tick();
        chk_wr("bubble", 1'b0, 5'd9, 64'hB, 1'b0);

        // Reset mid-stream drops the pending instruction
        issue(1'b1, 2'd0, F3_LB, 3'd0, 1'b1, 5'd4);
        tick();
        chk_wr("pre_reset", 1'b1, 5'd4, 64'hB, 1'b0);
        reset_n = 1'b0;
        tick();
        chk_wr("mid_reset", 1'b0, 5'd0, 64'd0, 1'b0);
        reset_n = 1'b1;
        issue(1'b0, 2'd0, F3_LB, 3'd0, 1'b0, 5'd0);
        tick();

        // Counter wrap from all-ones
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_ret = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(1'b1, 2'd0, F3_LB, 3'd0, 1'b1, 5'd6);
        tick();
        chk_wr("wrap_capture", 1'b1, 5'd6, 64'hB, 1'b0);
        release dut.instret_q;
        issue(1'b0, 2'd0, F3_LB, 3'd0, 1'b0, 5'd0);
        tick();
        chk("wrap.instret_zero", instret, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
